// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the dual-core MIPS main-memory arbiter.
//   arb_state_t : arbiter FSM states
//   CORE1/CORE2 : core identifiers used for grant ids and the priority pointer
//   LAT_CNT_W   : width of the memory-latency down-counter (MEM_LAT range 1..7)
package mips_mc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_t;

    localparam logic CORE1 = 1'b0;
    localparam logic CORE2 = 1'b1;

    localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_2p_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
//   slave  : arbiter view (consumes core requests and mem_q, drives acks, rdata, stalls, RAM pins)
//   master : environment view (cores and RAM model)
// Optional SNOOP_INV_EN adds inv1/inv2/inv_addr invalidate signals.
interface mem_arbiter_2p_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              req1;
    logic              req2;
    logic              we1;
    logic              we2;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] wdata2;
    logic              ack1;
    logic              ack2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              stall1;
    logic              stall2;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
`ifdef SNOOP_INV_EN
    logic              inv1;
    logic              inv2;
    logic [ADDR_W-1:0] inv_addr;
`endif

    modport slave (
        input  req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_q,
`ifdef SNOOP_INV_EN
        output inv1, inv2, inv_addr,
`endif
        output ack1, ack2, rdata1, rdata2, stall1, stall2,
        output mem_address, mem_data, mem_rden, mem_wren
    );

    modport master (
        output req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_q,
`ifdef SNOOP_INV_EN
        input  inv1, inv2, inv_addr,
`endif
        input  ack1, ack2, rdata1, rdata2, stall1, stall2,
        input  mem_address, mem_data, mem_rden, mem_wren
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Pure combinational; the pointer register lives in the caller.
//   req1_i, req2_i : core requests
//   ptr_i          : core that wins when both request
//   gnt_id_o       : winning core id (CORE1/CORE2), meaningful only when any_req_o
//   any_req_o      : at least one request pending
module rr_arb2
    import mips_mc_pkg::*;
(
    input  logic req1_i,
    input  logic req2_i,
    input  logic ptr_i,
    output logic gnt_id_o,
    output logic any_req_o
);

    always_comb begin
        any_req_o = req1_i | req2_i;
        if (req1_i && req2_i) begin
            gnt_id_o = ptr_i;
        end else if (req2_i) begin
            gnt_id_o = CORE2;
        end else begin
            gnt_id_o = CORE1;
        end
    end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Arbitrates the single main-memory port between two cache controllers.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, round-robin between cores.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_2p_if.slave (core handshakes, per-core rdata/stall, RAM pins)
// Optional macro SNOOP_INV_EN: on a granted write, pulse the other core's invalidate with the
// write address during RESP.
module mem_arbiter_2p
    import mips_mc_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input logic             clk,
    input logic             rst_n,
    mem_arbiter_2p_if.slave bus
);

    arb_state_t          state_q;
    logic                ptr_q;
    logic                id_q;
    logic                we_q;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic                ack1_q;
    logic                ack2_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic [DATA_W-1:0]   rdata2_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic [DATA_W-1:0]   mem_data_q;
    logic                mem_rden_q;
    logic                mem_wren_q;
`ifdef SNOOP_INV_EN
    logic                inv1_q;
    logic                inv2_q;
    logic [ADDR_W-1:0]   inv_addr_q;
`endif

    logic                gnt_id;
    logic                any_req;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req1_i    (bus.req1),
        .req2_i    (bus.req2),
        .ptr_i     (ptr_q),
        .gnt_id_o  (gnt_id),
        .any_req_o (any_req)
    );

    always_comb begin
        sel_we    = bus.we1;
        sel_addr  = bus.addr1;
        sel_wdata = bus.wdata1;
        if (gnt_id == CORE2) begin
            sel_we    = bus.we2;
            sel_addr  = bus.addr2;
            sel_wdata = bus.wdata2;
        end
    end

    // The latched address/data double as the RAM pins, so they stay stable from ISSUE to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= CORE1;
            id_q          <= CORE1;
            we_q          <= 1'b0;
            cnt_q         <= '0;
            ack1_q        <= 1'b0;
            ack2_q        <= 1'b0;
            rdata1_q      <= '0;
            rdata2_q      <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
`ifdef SNOOP_INV_EN
            inv1_q        <= 1'b0;
            inv2_q        <= 1'b0;
            inv_addr_q    <= '0;
`endif
        end else begin
            // Pulses default low; only the transitions below raise them for one cycle.
            ack1_q     <= 1'b0;
            ack2_q     <= 1'b0;
            mem_rden_q <= 1'b0;
            mem_wren_q <= 1'b0;
`ifdef SNOOP_INV_EN
            inv1_q     <= 1'b0;
            inv2_q     <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        id_q          <= gnt_id;
                        we_q          <= sel_we;
                        mem_address_q <= sel_addr;
                        mem_data_q    <= sel_wdata;
                        mem_wren_q    <= sel_we;
                        mem_rden_q    <= ~sel_we;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    // Counter holds remaining WAIT cycles minus one.
                    cnt_q   <= LAT_CNT_W'(MEM_LAT - 1);
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        if (!we_q) begin
                            if (id_q == CORE2) begin
                                rdata2_q <= bus.mem_q;
                            end else begin
                                rdata1_q <= bus.mem_q;
                            end
                        end
                        ack1_q  <= (id_q == CORE1);
                        ack2_q  <= (id_q == CORE2);
`ifdef SNOOP_INV_EN
                        if (we_q) begin
                            inv1_q     <= (id_q == CORE2);
                            inv2_q     <= (id_q == CORE1);
                            inv_addr_q <= mem_address_q;
                        end
`endif
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - LAT_CNT_W'(1);
                    end
                end
                StResp: begin
                    ptr_q   <= ~id_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ack1        = ack1_q;
    assign bus.ack2        = ack2_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.rdata2      = rdata2_q;
    assign bus.stall1      = bus.req1 & ~ack1_q;
    assign bus.stall2      = bus.req2 & ~ack2_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_rden    = mem_rden_q;
    assign bus.mem_wren    = mem_wren_q;
`ifdef SNOOP_INV_EN
    assign bus.inv1        = inv1_q;
    assign bus.inv2        = inv2_q;
    assign bus.inv_addr    = inv_addr_q;
`endif

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Self-checking bench for mem_arbiter_2p: reset, table-driven single transactions, contention,
// reset mid-transaction and a randomized two-core run against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter_2p;
    import mips_mc_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int          LAT    = 1;
    localparam int          ACK_N  = 2 + LAT;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_2p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter_2p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Registered-address RAM; unwritten words return a fixed pattern.
    bit   [31:0] ram    [0:1023];
    bit          ram_wr [0:1023];
    logic [31:0] ram_q;

    function automatic logic [31:0] ram_init(input logic [9:0] a);
        return (a == 10'h005) ? 32'hDEADBEEF : (32'hC0DE0000 | {22'd0, a});
    endfunction

    always @(posedge clk) begin
        if (bus.mem_wren) begin
            ram[bus.mem_address]    <= bus.mem_data;
            ram_wr[bus.mem_address] <= 1'b1;
        end
        ram_q <= ram_wr[bus.mem_address] ? ram[bus.mem_address] : ram_init(bus.mem_address);
    end
    assign bus.mem_q = ram_q;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit k, input bit req, input bit we, input logic [9:0] a,
                         input logic [31:0] d);
        if (k == CORE1) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req2 = req; bus.we2 = we; bus.addr2 = a; bus.wdata2 = d;
        end
    endtask

    function automatic logic ack_of(input bit k);
        return (k == CORE2) ? bus.ack2 : bus.ack1;
    endfunction
    function automatic logic stall_of(input bit k);
        return (k == CORE2) ? bus.stall2 : bus.stall1;
    endfunction
    function automatic logic [31:0] rdata_of(input bit k);
        return (k == CORE2) ? bus.rdata2 : bus.rdata1;
    endfunction
`ifdef SNOOP_INV_EN
    function automatic logic inv_of(input bit k);
        return (k == CORE2) ? bus.inv2 : bus.inv1;
    endfunction
`endif

    // Follows one transaction whose request is visible in the current (IDLE) cycle n=0.
    task automatic watch(input string tag, input bit k, input bit we, input logic [9:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd);
        for (int n = 0; n <= ACK_N; n++) begin
            @(negedge clk);
            check({tag, "_ack"}, 64'({ack_of(k), ack_of(!k)}), 64'({n == ACK_N, 1'b0}));
            check({tag, "_strobe"}, 64'({bus.mem_rden, bus.mem_wren}),
                  64'({n == 1 && !we, n == 1 && we}));
            check({tag, "_stall"}, 64'(stall_of(k)), 64'(n != ACK_N));
            if (n >= 1) check({tag, "_addr"}, 64'(bus.mem_address), 64'(a));
            if (n == 1 && we) check({tag, "_wdata"}, 64'(bus.mem_data), 64'(d));
            if (n == ACK_N) check({tag, "_rdata"}, 64'(rdata_of(k)), 64'(exp_rd));
`ifdef SNOOP_INV_EN
            check({tag, "_inv"}, 64'({inv_of(!k), inv_of(k)}), 64'({n == ACK_N && we, 1'b0}));
            if (n == ACK_N && we) check({tag, "_inv_addr"}, 64'(bus.inv_addr), 64'(a));
`endif
            if (n < ACK_N) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic single(input string tag, input bit k, input bit we, input logic [9:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        drive(k, 1'b1, we, a, d);
        watch(tag, k, we, a, d, exp_rd);
        @(posedge clk); #1;
        drive(k, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        bit          core;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs [6];

    // Contention / reset-abort bookkeeping
    int          got;
    int          last_c;
    int          acks;
    bit          drop1;
    logic [9:0]  caddr [2];

    // Random-phase reference model state
    bit          pend  [2];
    bit          pwe   [2];
    logic [9:0]  paddr [2];
    logic [31:0] pdat  [2];
    bit          acked [2];
    logic [31:0] mrd   [2];
    logic [31:0] ref_mem [16];
    bit          busy;
    bit          ptr;
    bit          rid;
    bit          rwe;
    logic [9:0]  raddr;
    logic [31:0] rexp;
    int          dec_c;
    int          ack_c;
    int          free_c;
    bit          e1;
    bit          e2;

    initial begin
        rst_n = 1'b0;
        drive(CORE1, 1'b0, 1'b0, '0, '0);
        drive(CORE2, 1'b0, 1'b0, '0, '0);

        // Reset held with a pending read: nothing moves.
        drive(CORE1, 1'b1, 1'b0, 10'h005, '0);
        repeat (2) @(negedge clk);
        check("rst_ack", 64'({bus.ack1, bus.ack2}), 64'(0));
        check("rst_strobe", 64'({bus.mem_rden, bus.mem_wren}), 64'(0));
        check("rst_stall", 64'({bus.stall1, bus.stall2}), 64'(2'b10));
        check("rst_rdata", 64'({bus.rdata1, bus.rdata2}), 64'(0));
        check("rst_addr", 64'(bus.mem_address), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        watch("rst_rel", CORE1, 1'b0, 10'h005, '0, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive(CORE1, 1'b0, 1'b0, '0, '0);

        // Single-requester table
        vecs[0] = '{core: CORE1, we: 1'b0, addr: 10'h005, wdata: 32'h0,        exp_rd: 32'hDEADBEEF};
        vecs[1] = '{core: CORE2, we: 1'b1, addr: 10'h3FF, wdata: 32'h12345678, exp_rd: 32'h0};
        vecs[2] = '{core: CORE2, we: 1'b0, addr: 10'h3FF, wdata: 32'h0,        exp_rd: 32'h12345678};
        vecs[3] = '{core: CORE1, we: 1'b1, addr: 10'h000, wdata: 32'hAAAA5555, exp_rd: 32'hDEADBEEF};
        vecs[4] = '{core: CORE2, we: 1'b0, addr: 10'h000, wdata: 32'h0,        exp_rd: 32'hAAAA5555};
        vecs[5] = '{core: CORE1, we: 1'b0, addr: 10'h3FF, wdata: 32'h0,        exp_rd: 32'h12345678};
        for (int i = 0; i < 6; i++) begin
            single($sformatf("vec%0d", i), vecs[i].core, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rd);
        end

        // Contention from reset: strict 1,2,1,2 with fixed spacing.
        do_reset();
        @(posedge clk); #1;
        caddr[0] = 10'h010;
        caddr[1] = 10'h020;
        drive(CORE1, 1'b1, 1'b0, caddr[0], '0);
        drive(CORE2, 1'b1, 1'b0, caddr[1], '0);
        got    = 0;
        last_c = 0;
        for (int c = 0; c < 80 && got < 8; c++) begin
            @(negedge clk);
            if (bus.ack1 && bus.ack2) check("cont_both_ack", 64'(1), 64'(0));
            if (bus.ack1 || bus.ack2) begin
                check("cont_order", 64'(bus.ack2), 64'(got % 2));
                if (got == 0) check("cont_first_lat", 64'(c), 64'(ACK_N));
                else check("cont_gap", 64'(c - last_c), 64'(ACK_N + 1));
                check("cont_rdata", 64'(rdata_of(bus.ack2)), 64'(ram_init(caddr[bus.ack2])));
                last_c = c;
                got++;
                @(posedge clk); #1;
                caddr[got % 2 == 1 ? 0 : 1] = caddr[got % 2 == 1 ? 0 : 1] + 10'd1;
                drive(CORE1, 1'b1, 1'b0, caddr[0], '0);
                drive(CORE2, 1'b1, 1'b0, caddr[1], '0);
            end else begin
                @(posedge clk); #1;
            end
        end
        check("cont_count", 64'(got), 64'(8));
        drive(CORE1, 1'b0, 1'b0, '0, '0);
        drive(CORE2, 1'b0, 1'b0, '0, '0);

        // Reset during an in-flight read: abort, then reissue once.
        @(posedge clk); #1;
        drive(CORE1, 1'b1, 1'b0, 10'h005, '0);
        @(posedge clk); #2;
        check("abort_pre_rden", 64'(bus.mem_rden), 64'(1));
        rst_n = 1'b0;
        #1;
        check("abort_strobe", 64'({bus.mem_rden, bus.mem_wren}), 64'(0));
        check("abort_rdata", 64'(bus.rdata1), 64'(0));
        repeat (2) begin
            @(negedge clk);
            check("abort_ack", 64'({bus.ack1, bus.ack2}), 64'(0));
            check("abort_stall", 64'(bus.stall1), 64'(1));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        acks  = 0;
        drop1 = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.ack1) begin
                acks++;
                check("abort_lat", 64'(n), 64'(ACK_N));
                check("abort_rd", 64'(bus.rdata1), 64'(32'hDEADBEEF));
                drop1 = 1'b1;
            end
            @(posedge clk); #1;
            if (drop1) drive(CORE1, 1'b0, 1'b0, '0, '0);
        end
        check("abort_acks", 64'(acks), 64'(1));

        // Randomized two-core traffic against a transaction-level model.
        drive(CORE1, 1'b0, 1'b0, '0, '0);
        drive(CORE2, 1'b0, 1'b0, '0, '0);
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = ram_init(10'h100 + 10'(i));
        mrd[0] = '0; mrd[1] = '0;
        busy = 1'b0; ptr = CORE1; free_c = 0; dec_c = 0; ack_c = 0;
        rid = CORE1; rwe = 1'b0; raddr = '0; rexp = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (acked[k]) begin
                    pend[k]  = 1'b0;
                    acked[k] = 1'b0;
                end
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k]  = 1'b1;
                    pwe[k]   = 1'($urandom_range(0, 1));
                    paddr[k] = 10'h100 + 10'($urandom_range(0, 15));
                    pdat[k]  = $urandom;
                end
                drive(1'(k), pend[k], pend[k] & pwe[k], pend[k] ? paddr[k] : '0,
                      pend[k] ? pdat[k] : '0);
            end
            @(negedge clk);
            if (!busy && c >= free_c && (pend[0] || pend[1])) begin
                rid   = (pend[0] && pend[1]) ? ptr : (pend[1] ? CORE2 : CORE1);
                busy  = 1'b1;
                dec_c = c;
                ack_c = c + ACK_N;
                rwe   = pwe[rid];
                raddr = paddr[rid];
                if (rwe) ref_mem[raddr[3:0]] = pdat[rid];
                else rexp = ref_mem[raddr[3:0]];
            end
            e1 = busy && c == ack_c && rid == CORE1;
            e2 = busy && c == ack_c && rid == CORE2;
            if (busy && c == ack_c && !rwe) mrd[rid] = rexp;
            check("rnd_ack", 64'({bus.ack1, bus.ack2}), 64'({e1, e2}));
            check("rnd_strobe", 64'({bus.mem_rden, bus.mem_wren}),
                  64'({busy && c == dec_c + 1 && !rwe, busy && c == dec_c + 1 && rwe}));
            check("rnd_stall", 64'({bus.stall1, bus.stall2}),
                  64'({pend[0] && !e1, pend[1] && !e2}));
            check("rnd_rdata", {bus.rdata1, bus.rdata2}, {mrd[0], mrd[1]});
            if (busy && c > dec_c) check("rnd_addr", 64'(bus.mem_address), 64'(raddr));
            if (busy && c == dec_c + 1 && rwe) check("rnd_wdata", 64'(bus.mem_data), 64'(pdat[rid]));
`ifdef SNOOP_INV_EN
            check("rnd_inv", 64'({bus.inv1, bus.inv2}), 64'({e2 && rwe, e1 && rwe}));
            if ((e1 || e2) && rwe) check("rnd_inv_addr", 64'(bus.inv_addr), 64'(raddr));
`endif
            if (busy && c == ack_c) begin
                busy       = 1'b0;
                free_c     = c + 1;
                ptr        = ~rid;
                acked[rid] = 1'b1;
            end
        end
        drive(CORE1, 1'b0, 1'b0, '0, '0);
        drive(CORE2, 1'b0, 1'b0, '0, '0);
        repeat (8) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
